// File: rtl/alp_pkg.sv
// Shared definitions for the ALP cipher engines: S-box tables, GF(2^8) helpers,
// the per-round rotation amount and the iterative engine state encoding.
package alp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} alp_state_t;

    localparam logic [7:0] GF_POLY = 8'h1B;

    // Nibble v of every table sits at bits [4v+3:4v].
    localparam logic [63:0] SBOX [4] = '{
        64'h0123456789ABCDEF,
        64'h543210EDCBA9876F,
        64'hBA9EDC601572438F,
        64'hEDC01245B3A6987F
    };

    localparam logic [63:0] SBOX_INV [4] = '{
        64'h0123456789ABCDEF,
        64'h0987654321FEDCBA,
        64'h0CBAFED159632478,
        64'h0FED753214896ABC
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    // Rotation is 1..8; a value of 8 means the byte passes through unrotated.
    function automatic logic [3:0] rho(input logic [3:0] r);
        return (r & 4'd7) + 4'd1;
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [1:0] sel, input logic [3:0] v);
        logic [63:0] w;
        w = SBOX[sel];
        return w[{v, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv_lookup(input logic [1:0] sel, input logic [3:0] v);
        logic [63:0] w;
        w = SBOX_INV[sel];
        return w[{v, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/encralp_round.sv
// One combinational ALP encryption round: key whitening, inverse S-box layer,
// MixColumns, per-round byte rotation and output key mix.
module encralp_round
    import alp_pkg::*;
(
    input  logic [31:0]  state_in,
    input  logic [255:0] key,
    input  logic [3:0]   r,
    output logic [31:0]  state_out
);

    logic [31:0]     p;
    logic [31:0]     m;
    logic [7:0]      b1, b2, b3, b4;
    logic [3:0][7:0] a;
    logic [3:0]      rot;

    function automatic logic [7:0] kbyte(input logic [255:0] k, input logic [4:0] idx);
        return k[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [1:0] ksel(input logic [255:0] k, input logic [4:0] idx);
        return k[{idx, 3'b000} +: 2];
    endfunction

    // A shift of the doubled byte gives a left rotate, and a shift of 8 is identity.
    function automatic logic [7:0] rotl(input logic [7:0] v, input logic [3:0] n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    always_comb begin
        p = '0;
        m = '0;
        for (int j = 0; j < 4; j++)
            p[8*j +: 8] = state_in[8*j +: 8] ^ kbyte(key, {1'b0, r} + 5'(j));
        for (int k = 0; k < 8; k++)
            m[4*k +: 4] = sbox_inv_lookup(ksel(key, {1'b0, r} + 5'(2*k)), p[4*k +: 4]);
    end

    assign b3 = m[7:0];
    assign b4 = m[15:8];
    assign b1 = m[23:16];
    assign b2 = m[31:24];

    assign a[0] = xtime(b1) ^ xtime(b2) ^ b2 ^ b3 ^ b4;
    assign a[1] = b1 ^ xtime(b2) ^ xtime(b3) ^ b3 ^ b4;
    assign a[2] = b1 ^ b2 ^ xtime(b3) ^ xtime(b4) ^ b4;
    assign a[3] = xtime(b1) ^ b1 ^ b2 ^ b3 ^ xtime(b4);

    assign rot = rho(r);

    always_comb begin
        state_out = '0;
        for (int j = 0; j < 4; j++)
            state_out[8*j +: 8] = rotl(a[j], rot) ^ kbyte(key, 5'd28 - {1'b0, r} + 5'(j));
    end

endmodule

// File: rtl/encralp_iter.sv
// Iterative ALP encryption engine: accepts a block and key, runs one round per
// clock through a shared round datapath, then holds the ciphertext until taken.
module encralp_iter
    import alp_pkg::*;
#(
    parameter int NROUNDS = 16
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in1,
    input  logic [7:0]   in2,
    input  logic [7:0]   in3,
    input  logic [7:0]   in4,
    input  logic [255:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out1,
    output logic [7:0]   out2,
    output logic [7:0]   out3,
    output logic [7:0]   out4,
    output logic         busy
);

    localparam logic [3:0] LAST_RC = 4'(NROUNDS - 1);

    alp_state_t   st;
    logic [31:0]  data;
    logic [31:0]  rnd_out;
    logic [255:0] key_q;
    logic [3:0]   rc;

    encralp_round u_round (
        .state_in  (data),
        .key       (key_q),
        .r         (rc),
        .state_out (rnd_out)
    );

    // Handshake flags are registered alongside the state so they decode the state only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out1      <= 8'h00;
            out2      <= 8'h00;
            out3      <= 8'h00;
            out4      <= 8'h00;
            rc        <= 4'd0;
            data      <= '0;
            key_q     <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        data     <= {in4, in3, in2, in1};
                        key_q    <= key;
                        rc       <= 4'd0;
                        st       <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    data <= rnd_out;
                    if (rc == LAST_RC) begin
                        {out4, out3, out2, out1} <= rnd_out;
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end else begin
                        rc <= rc + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= IDLE;
                    end
                end
                default: begin
                    st        <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encralp_iter.sv
// Bench for encralp_iter: a single-round instance for hand-computed vectors and a
// 16-round instance checked through an independent decryption reference.
module tb_encralp_iter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [7:0]   s_in1, s_in2, s_in3, s_in4, s_out1, s_out2, s_out3, s_out4;
    logic [255:0] s_key;

    logic         f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_busy;
    logic [7:0]   f_in1, f_in2, f_in3, f_in4, f_out1, f_out2, f_out3, f_out4;
    logic [255:0] f_key;

    int checks = 0;
    int failures = 0;

    encralp_iter #(.NROUNDS(1)) u_single (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in1(s_in1), .in2(s_in2), .in3(s_in3), .in4(s_in4), .key(s_key),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out1(s_out1), .out2(s_out2), .out3(s_out3), .out4(s_out4),
        .busy(s_busy)
    );

    encralp_iter #(.NROUNDS(16)) u_full (
        .clk(clk), .rst_n(rst_n),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in1(f_in1), .in2(f_in2), .in3(f_in3), .in4(f_in4), .key(f_key),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out1(f_out1), .out2(f_out2), .out3(f_out3), .out4(f_out4),
        .busy(f_busy)
    );

    // Forward S-boxes written in input order v = 0..15.
    localparam logic [3:0] S_FWD [4][16] = '{
        '{4'hF,4'hE,4'hD,4'hC,4'hB,4'hA,4'h9,4'h8,4'h7,4'h6,4'h5,4'h4,4'h3,4'h2,4'h1,4'h0},
        '{4'hF,4'h6,4'h7,4'h8,4'h9,4'hA,4'hB,4'hC,4'hD,4'hE,4'h0,4'h1,4'h2,4'h3,4'h4,4'h5},
        '{4'hF,4'h8,4'h3,4'h4,4'h2,4'h7,4'h5,4'h1,4'h0,4'h6,4'hC,4'hD,4'hE,4'h9,4'hA,4'hB},
        '{4'hF,4'h7,4'h8,4'h9,4'h6,4'hA,4'h3,4'hB,4'h5,4'h4,4'h2,4'h1,4'h0,4'hC,4'hD,4'hE}
    };

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res;
        logic [7:0] x;
        res = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) res = res ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return res;
    endfunction

    function automatic logic [31:0] dec_round(input logic [31:0] y, input logic [255:0] k, input int r);
        logic [7:0]  a [4];
        logic [7:0]  t, b1, b2, b3, b4;
        logic [31:0] m, p, x;
        logic [1:0]  sel;
        int          rho;
        rho = (r % 8) + 1;
        for (int j = 0; j < 4; j++) begin
            t = y[8*j +: 8] ^ k[8*(28-r+j) +: 8];
            a[j] = (rho == 8) ? t : ((t >> rho) | (t << (8 - rho)));
        end
        b1 = gmul(a[0], 8'd14) ^ gmul(a[1], 8'd11) ^ gmul(a[2], 8'd13) ^ gmul(a[3], 8'd9);
        b2 = gmul(a[0], 8'd9)  ^ gmul(a[1], 8'd14) ^ gmul(a[2], 8'd11) ^ gmul(a[3], 8'd13);
        b3 = gmul(a[0], 8'd13) ^ gmul(a[1], 8'd9)  ^ gmul(a[2], 8'd14) ^ gmul(a[3], 8'd11);
        b4 = gmul(a[0], 8'd11) ^ gmul(a[1], 8'd13) ^ gmul(a[2], 8'd9)  ^ gmul(a[3], 8'd14);
        m = {b2, b1, b4, b3};
        for (int n = 0; n < 8; n++) begin
            sel = k[8*(r+2*n) +: 2];
            p[4*n +: 4] = S_FWD[sel][m[4*n +: 4]];
        end
        for (int j = 0; j < 4; j++)
            x[8*j +: 8] = p[8*j +: 8] ^ k[8*(r+j) +: 8];
        return x;
    endfunction

    function automatic logic [31:0] decrypt16(input logic [31:0] ct, input logic [255:0] k);
        logic [31:0] x;
        x = ct;
        for (int r = 15; r >= 0; r--) x = dec_round(x, k, r);
        return x;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom;
        return k;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_key = '0;
        {s_in4, s_in3, s_in2, s_in1} = 32'h0;
        f_in_valid = 1'b0; f_out_ready = 1'b0; f_key = '0;
        {f_in4, f_in3, f_in2, f_in1} = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_in_ready, s_out_valid, s_busy} !== 3'b100 || {s_out4, s_out3, s_out2, s_out1} !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_single: ready/valid/busy=%b outs=%h, expected 100 outs=00000000",
                     {s_in_ready, s_out_valid, s_busy}, {s_out4, s_out3, s_out2, s_out1});
        end
        checks++;
        if ({f_in_ready, f_out_valid, f_busy} !== 3'b100 || {f_out4, f_out3, f_out2, f_out1} !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_full: ready/valid/busy=%b outs=%h, expected 100 outs=00000000",
                     {f_in_ready, f_out_valid, f_busy}, {f_out4, f_out3, f_out2, f_out1});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({f_in_ready, f_out_valid, f_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL reset_release: ready/valid/busy=%b, expected 100", {f_in_ready, f_out_valid, f_busy});
        end
    endtask

    task automatic test_single_round(input string name, input logic [31:0] pt,
                                     input logic [31:0] expct, input bit scramble);
        {s_in4, s_in3, s_in2, s_in1} = pt;
        s_key = '0;
        s_in_valid = 1'b1;
        s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        if (scramble) begin
            s_key = rand_key();
            {s_in4, s_in3, s_in2, s_in1} = $urandom;
        end
        checks++;
        if ({s_in_ready, s_out_valid, s_busy} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL %s_run: ready/valid/busy=%b, expected 001", name, {s_in_ready, s_out_valid, s_busy});
        end
        @(negedge clk);
        checks++;
        if (s_out_valid !== 1'b1 || {s_out4, s_out3, s_out2, s_out1} !== expct) begin
            failures++;
            $display("[TB] FAIL %s_out: valid=%b out4..1=%h, expected valid=1 out4..1=%h",
                     name, s_out_valid, {s_out4, s_out3, s_out2, s_out1}, expct);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        checks++;
        if ({s_in_ready, s_out_valid, s_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL %s_consume: ready/valid/busy=%b, expected 100", name, {s_in_ready, s_out_valid, s_busy});
        end
    endtask

    // Back-to-back blocks with out_ready held high, so each block takes NROUNDS+2 cycles.
    task automatic test_roundtrip(input int n);
        logic [255:0] k;
        logic [31:0]  pt, ct;
        int           cyc;
        f_out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            k = rand_key();
            pt = $urandom;
            {f_in4, f_in3, f_in2, f_in1} = pt;
            f_key = k;
            f_in_valid = 1'b1;
            @(negedge clk);
            f_in_valid = 1'b0;
            f_key = ~k;
            {f_in4, f_in3, f_in2, f_in1} = ~pt;
            cyc = 0;
            while (f_out_valid !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != 16) begin
                failures++;
                $display("[TB] FAIL rt_latency[%0d]: cycles=%0d, expected 16", i, cyc);
            end
            ct = {f_out4, f_out3, f_out2, f_out1};
            @(negedge clk);
            checks++;
            if ({f_in_ready, f_out_valid, f_busy} !== 3'b100) begin
                failures++;
                $display("[TB] FAIL rt_consume[%0d]: ready/valid/busy=%b, expected 100", i, {f_in_ready, f_out_valid, f_busy});
            end
            checks++;
            if (decrypt16(ct, k) !== pt) begin
                failures++;
                $display("[TB] FAIL rt_plaintext[%0d]: decrypted=%h, expected %h (ct=%h)", i, decrypt16(ct, k), pt, ct);
            end
        end
        f_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        logic [31:0]  pt, ct;
        int           cyc;
        bit           stable;
        k = rand_key();
        pt = $urandom;
        {f_in4, f_in3, f_in2, f_in1} = pt;
        f_key = k;
        f_in_valid = 1'b1;
        f_out_ready = 1'b0;
        @(negedge clk);
        f_in_valid = 1'b0;
        cyc = 0;
        while (f_out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 16) begin
            failures++;
            $display("[TB] FAIL bp_latency: cycles=%0d, expected 16", cyc);
        end
        ct = {f_out4, f_out3, f_out2, f_out1};
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            f_in_valid = c[0];
            f_key = rand_key();
            {f_in4, f_in3, f_in2, f_in1} = $urandom;
            @(negedge clk);
            if ({f_out4, f_out3, f_out2, f_out1} !== ct || {f_in_ready, f_out_valid, f_busy} !== 3'b011) begin
                stable = 1'b0;
                $display("[TB] FAIL bp_hold[%0d]: outs=%h ready/valid/busy=%b, expected outs=%h 011",
                         c, {f_out4, f_out3, f_out2, f_out1}, {f_in_ready, f_out_valid, f_busy}, ct);
            end
        end
        checks++;
        if (!stable) failures++;
        checks++;
        if (decrypt16(ct, k) !== pt) begin
            failures++;
            $display("[TB] FAIL bp_plaintext: decrypted=%h, expected %h", decrypt16(ct, k), pt);
        end
        f_in_valid = 1'b0;
        f_out_ready = 1'b1;
        @(negedge clk);
        f_out_ready = 1'b0;
        checks++;
        if ({f_in_ready, f_out_valid, f_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bp_release: ready/valid/busy=%b, expected 100", {f_in_ready, f_out_valid, f_busy});
        end
        @(negedge clk);
        checks++;
        if ({f_in_ready, f_out_valid, f_busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bp_idle: ready/valid/busy=%b, expected 100", {f_in_ready, f_out_valid, f_busy});
        end
    endtask

    task automatic test_reset_mid_run();
        bit quiet;
        f_key = rand_key();
        {f_in4, f_in3, f_in2, f_in1} = $urandom;
        f_in_valid = 1'b1;
        f_out_ready = 1'b1;
        @(negedge clk);
        f_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({f_in_ready, f_out_valid, f_busy} !== 3'b001) begin
            failures++;
            $display("[TB] FAIL midrst_run: ready/valid/busy=%b, expected 001", {f_in_ready, f_out_valid, f_busy});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_in_ready, f_out_valid, f_busy} !== 3'b100 || {f_out4, f_out3, f_out2, f_out1} !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midrst_async: ready/valid/busy=%b outs=%h, expected 100 outs=00000000",
                     {f_in_ready, f_out_valid, f_busy}, {f_out4, f_out3, f_out2, f_out1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (f_out_valid !== 1'b0 || f_in_ready !== 1'b1 || f_busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("[TB] FAIL midrst_quiet: engine left idle or raised out_valid after reset, expected idle for 20 cycles");
        end
        f_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_round("zeros", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        test_single_round("onebit", 32'h0000_0001, 32'hFDFB_F9FD, 1'b0);
        test_single_round("keychange", 32'h0000_0001, 32'hFDFB_F9FD, 1'b1);
        test_roundtrip(1000);
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
